fsm_serializer: RTL and testbench
=================================

Name: fsm_serializer

Overview:
- Serial transmitter for the 3-bit MSB-first slicing link. It is the driving end of the serial odd-number detector FSM.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first, in fixed WIDTH-bit slots.
- Slot alignment never breaks. When no word is pending, an all-zero filler slot is sent, so the downstream slicer stays word-aligned.
- Also flags odd words as they leave, so benches can cross-check the receiver's output.

Parameters:
WIDTH, 3, bits per slot/word; must be >= 2.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word to transmit, MSB sent first
data_valid  input  1  data_in holds a word to send
data_ready  output  1  holding buffer empty; word accepted on an edge where data_valid && data_ready
out  output  1  serial bit stream, one bit per clock
frame  output  1  high during the first (MSB) bit of every slot, real or filler
busy  output  1  high for all WIDTH bits of a slot carrying a real word; low for filler slots
odd_sent  output  1  high during the LSB bit of a real word whose LSB is 1

Behaviour:
- Reset is synchronous and active-high. While reset is high at an edge:
  - out=0, frame=0, busy=0, odd_sent=0, data_ready=1.
  - Holding buffer empty; shift register cleared.
  - Bit counter set to WIDTH-1, so the first edge after reset deasserts is a slot boundary.
- State:
  - Holding register plus hold_full flag (1-entry buffer).
  - WIDTH-bit shift register sr.
  - Bit counter cnt, 0..WIDTH-1.
  - real flag for the current slot.
- data_ready = ~hold_full. It is registered state, not combinational on data_valid.
- Accept: on an edge with data_valid && data_ready, capture data_in into hold and set hold_full. data_in is ignored when data_ready=0.
- Slot boundary (edge where cnt==WIDTH-1):
  - cnt<=0.
  - If hold_full: sr<=hold, real<=1, hold_full<=0.
  - Otherwise: sr<=0, real<=0 (filler slot).
  - A word presented at a boundary edge with an empty holding buffer goes into hold, not directly into sr. There is no bypass.
- Non-boundary edge: cnt<=cnt+1, sr<=sr<<1 (zero fill).
- Outputs are registered and valid the cycle after the edge:
  - out = sr MSB.
  - frame = (cnt==0).
  - busy = real.
  - odd_sent = real && cnt==WIDTH-1 && transmitted LSB==1.
- Latency: a word accepted at edge E has its MSB on out after the first boundary edge strictly later than E. Worst case is WIDTH edges after acceptance.
- Throughput: one word per WIDTH cycles. Hold refills during the current slot, so a source that re-presents within WIDTH-1 cycles gets back-to-back real slots with no filler.
- hold_full cannot be set and cleared on the same edge, because data_ready=0 while full.
- Reset mid-slot:
  - The current word and any held word are discarded; no partial bits continue.
  - out=0 the cycle after the reset edge.
  - The slot grid restarts from the first post-reset edge.
- Filler slots:
  - out=0 for WIDTH bits, frame pulses on bit 0, busy=0, odd_sent=0.
  - The receiver sees them as value 0, which is even and causes no output.

Test Plan:
- Reset is held 2 cycles, then released with data_valid=0 for 9 cycles. Required: out=0 throughout, frame pulses on every third cycle starting with the first post-reset cycle, busy=0, odd_sent=0, data_ready=1.
- data_in=3'b101 with data_valid=1 at post-reset edge 1, dropped after acceptance. Required:
  - data_ready=0 after edge 1.
  - Filler occupies edges 1-3.
  - out=1,0,1 after edges 4,5,6, with frame=1 after edge 4 and busy=1 after edges 4-6.
  - odd_sent=1 only after edge 6.
  - data_ready=1 again after edge 4.
- Words 3'b110, 3'b011, 3'b111 presented each as soon as data_ready=1. Required:
  - Contiguous serial stream 110011111 with no filler between slots.
  - odd_sent pulses on the LSB cycles of 011 and 111 only.
- data_valid held high with data_ready=0 while hold is full and data_in changes 3'b001 -> 3'b100 before ready returns. Required: only the accepted value is transmitted; the changed value is captured only on the edge where data_ready=1.
- Reset asserted on the middle bit of a 3'b111 slot with another word held. Required: out=0 the next cycle, the held word is never sent, data_ready=1, and the first post-reset slot is filler.
- WIDTH=4 instance, word 4'b1001. Required: out=1,0,0,1 over 4 cycles, frame every 4th cycle, odd_sent on the 4th bit.

Source files
------------

// File: rtl/fsm_serializer.sv
// fsm_serializer
//   Serial transmitter for a WIDTH-bit, MSB-first slicing link. Parallel words
//   arrive over a valid/ready handshake into a one-entry holding buffer and
//   leave one bit per clock in fixed WIDTH-bit slots. When no word is waiting
//   at a slot boundary an all-zero filler slot is sent, so the receiver never
//   loses word alignment. Words with LSB=1 are flagged as they finish.
//
// Ports
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   data_in     parallel word to send (MSB first)
//   data_valid  data_in holds a word to send
//   data_ready  holding buffer empty; word taken when data_valid && data_ready
//   out         serial bit stream
//   frame       high on the first (MSB) bit of every slot, real or filler
//   busy        high for every bit of a slot carrying a real word
//   odd_sent    high on the LSB bit of a real word whose LSB is 1
module fsm_serializer #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             out,
   output logic             frame,
   output logic             busy,
   output logic             odd_sent
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   // Kind of slot currently on the wire.
   typedef enum logic {
      SlotFiller,
      SlotReal
   } slot_e;

   slot_e            slot_q, slot_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic out_q, out_d;
   logic frame_q, frame_d;
   logic busy_q, busy_d;
   logic odd_q, odd_d;

   logic accept;
   logic boundary;

   assign accept   = data_valid && !hold_full_q;
   assign boundary = (cnt_q == CntLast);

   // Next-state and registered-output decode.
   always_comb begin
      slot_d      = slot_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;

      if (boundary) begin
         cnt_d = '0;
         if (hold_full_q) begin
            sr_d        = hold_q;
            slot_d      = SlotReal;
            hold_full_d = 1'b0;
         end else begin
            sr_d   = '0;
            slot_d = SlotFiller;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
         sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      end

      // Accept only when empty, so this never collides with the unload above:
      // a word arriving on a boundary edge waits in hold for the next slot.
      if (accept) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      out_d   = sr_d[WIDTH-1];
      frame_d = (cnt_d == '0);
      busy_d  = (slot_d == SlotReal);
      // On the last bit of a slot the MSB of sr is the word's original LSB.
      odd_d   = busy_d && (cnt_d == CntLast) && sr_d[WIDTH-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_q      <= SlotFiller;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         sr_q        <= '0;
         cnt_q       <= CntLast;  // first edge after reset is a slot boundary
         out_q       <= 1'b0;
         frame_q     <= 1'b0;
         busy_q      <= 1'b0;
         odd_q       <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         frame_q     <= frame_d;
         busy_q      <= busy_d;
         odd_q       <= odd_d;
      end
   end

   assign data_ready = ~hold_full_q;
   assign out        = out_q;
   assign frame      = frame_q;
   assign busy       = busy_q;
   assign odd_sent   = odd_q;

endmodule

// File: tb/tb_fsm_serializer.sv
// Bench for fsm_serializer: one WIDTH=3 and one WIDTH=4 instance, each checked
// every cycle against a slot-level reference model (edge count since reset
// selects the bit position; a one-deep queue stands in for the buffer).
module tb_fsm_serializer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       r3 = 1'b1, v3 = 1'b0;
   logic [2:0] d3 = '0;
   logic       rd3, o3, f3, b3, s3;
   logic       r4 = 1'b1, v4 = 1'b0;
   logic [3:0] d4 = '0;
   logic       rd4, o4, f4, b4, s4;

   fsm_serializer #(.WIDTH(3)) dut3 (
      .clock(clock), .reset(r3), .data_in(d3), .data_valid(v3), .data_ready(rd3),
      .out(o3), .frame(f3), .busy(b3), .odd_sent(s3)
   );

   fsm_serializer #(.WIDTH(4)) dut4 (
      .clock(clock), .reset(r4), .data_in(d4), .data_valid(v4), .data_ready(rd4),
      .out(o4), .frame(f4), .busy(b4), .odd_sent(s4)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state, index 0 = WIDTH 3, index 1 = WIDTH 4.
   int         m_edges[2];
   logic [3:0] m_hold[2];
   bit         m_full[2];
   logic [3:0] m_slot[2];
   bit         m_real[2];

   // One clock for instance k: sample its inputs, advance the model, compare.
   task automatic step(input int k, output bit acc);
      logic rst, vld, eo, ef, eb, es, er;
      logic [3:0] din;
      int w, pos;
      bit rdy_pre;
      w   = (k == 0) ? 3 : 4;
      rst = (k == 0) ? r3 : r4;
      vld = (k == 0) ? v3 : v4;
      din = (k == 0) ? {1'b0, d3} : d4;
      acc = 1'b0;
      @(posedge clock);
      if (rst) begin
         m_edges[k] = 0;
         m_full[k]  = 1'b0;
         m_real[k]  = 1'b0;
         m_slot[k]  = '0;
         eo = 1'b0; ef = 1'b0; eb = 1'b0; es = 1'b0;
      end else begin
         rdy_pre = !m_full[k];
         pos = m_edges[k] % w;
         m_edges[k]++;
         if (pos == 0) begin
            if (m_full[k]) begin
               m_slot[k] = m_hold[k];
               m_real[k] = 1'b1;
               m_full[k] = 1'b0;
            end else begin
               m_slot[k] = '0;
               m_real[k] = 1'b0;
            end
         end
         if (vld && rdy_pre) begin
            m_hold[k] = din;
            m_full[k] = 1'b1;
            acc = 1'b1;
         end
         eo = m_slot[k][w-1-pos];
         ef = (pos == 0);
         eb = m_real[k];
         es = m_real[k] && (pos == w - 1) && m_slot[k][0];
      end
      er = !m_full[k];
      #1;
      if (k == 0) begin
         check_eq("w3 out", {3'b0, o3}, {3'b0, eo});
         check_eq("w3 frame", {3'b0, f3}, {3'b0, ef});
         check_eq("w3 busy", {3'b0, b3}, {3'b0, eb});
         check_eq("w3 odd_sent", {3'b0, s3}, {3'b0, es});
         check_eq("w3 data_ready", {3'b0, rd3}, {3'b0, er});
      end else begin
         check_eq("w4 out", {3'b0, o4}, {3'b0, eo});
         check_eq("w4 frame", {3'b0, f4}, {3'b0, ef});
         check_eq("w4 busy", {3'b0, b4}, {3'b0, eb});
         check_eq("w4 odd_sent", {3'b0, s4}, {3'b0, es});
         check_eq("w4 data_ready", {3'b0, rd4}, {3'b0, er});
      end
   endtask

   task automatic idle(input int k, input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(k, acc);
   endtask

   // Present a word and keep it valid until the model says it was taken.
   task automatic send(input int k, input logic [3:0] word, input bit drop);
      bit acc, done;
      done = 1'b0;
      if (k == 0) begin v3 = 1'b1; d3 = word[2:0]; end
      else begin v4 = 1'b1; d4 = word; end
      for (int i = 0; i < 12 && !done; i++) begin
         step(k, acc);
         done = acc;
      end
      check_eq("accept within budget", {3'b0, done}, 4'd1);
      if (drop) begin
         if (k == 0) v3 = 1'b0;
         else v4 = 1'b0;
      end
   endtask

   task automatic do_reset(input int k, input int n);
      if (k == 0) begin r3 = 1'b1; v3 = 1'b0; end
      else begin r4 = 1'b1; v4 = 1'b0; end
      idle(k, n);
      if (k == 0) r3 = 1'b0;
      else r4 = 1'b0;
   endtask

   task automatic random_run(input int k, input int n);
      bit acc;
      for (int i = 0; i < n; i++) begin
         if (k == 0) begin
            r3 = ($urandom_range(0, 49) == 0);
            v3 = $urandom_range(0, 1);
            d3 = 3'($urandom);
         end else begin
            r4 = ($urandom_range(0, 49) == 0);
            v4 = $urandom_range(0, 1);
            d4 = 4'($urandom);
         end
         step(k, acc);
      end
      if (k == 0) begin r3 = 1'b0; v3 = 1'b0; end
      else begin r4 = 1'b0; v4 = 1'b0; end
   endtask

   initial begin
      // WIDTH=3: reset, idle filler slots.
      do_reset(0, 2);
      idle(0, 9);
      // Single odd word, accepted on a boundary edge, lands in the next slot.
      do_reset(0, 2);
      send(0, 4'b0101, 1'b1);
      idle(0, 8);
      // Back-to-back words, no filler between them.
      send(0, 4'b0110, 1'b1);
      send(0, 4'b0011, 1'b1);
      send(0, 4'b0111, 1'b1);
      idle(0, 9);
      // Data changes while held off: only accepted values go out.
      send(0, 4'b0001, 1'b0);
      d3 = 3'b100;
      send(0, 4'b0100, 1'b1);
      idle(0, 9);
      // Reset on the middle bit of 111 with 010 held.
      send(0, 4'b0111, 1'b1);
      send(0, 4'b0010, 1'b1);
      do_reset(0, 1);
      idle(0, 9);
      random_run(0, 400);
      idle(0, 6);
      r3 = 1'b1;

      // WIDTH=4 instance.
      do_reset(1, 2);
      idle(1, 3);
      send(1, 4'b1001, 1'b1);
      idle(1, 12);
      random_run(1, 400);
      idle(1, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
